disp_stream_filter: RTL and testbench
=====================================

// Module: disp_stream_filter
// PURPOSE
//  Consumes the decimated XOR bit stream plus per-block confidence/disparity from the xor-to-stream
//  stage and emits one 8-bit disparity pixel per DxD XOR cell in raster order. Each pixel is gated
//  by an XOR-popcount and confidence threshold. Short invalid runs are hole-filled from the last
//  valid pixel. Feeds the depth output formatter; no backpressure on either side.
// PARAMETERS
//  FRAME_W    240  input frame width in pixels
//  FRAME_H    240  input frame height in pixels (multiple of BLK_H)
//  DECIMATE     2  D; XOR bits per input beat and beats per output pixel
//  DISP_BITS    5  meaningful disparity bits ($clog2(SEARCH_BLK_W-BLK_W)); upper disp_in bits ignored
//  MAX_HOLE     4  max consecutive invalid pixels filled per row
// PORTS
//  clk               in   1         clock
//  reset             in   1         synchronous, active-high
//  pix_stream_data   in   DECIMATE  XOR bits of one small row of current cell (1 = mismatch)
//  pix_stream_valid  in   1         beat qualifier; conf_in/disp_in aligned to it
//  conf_in           in   8         block confidence
//  disp_in           in   8         block disparity, [DISP_BITS-1:0] used
//  xor_thresh        in   3         max mismatch popcount for a valid pixel (quasi-static)
//  conf_thresh       in   8         min confidence for a valid pixel (quasi-static)
//  disp_out          out  8         disparity, zero-extended; 0 when invalid and not filled
//  disp_valid_flag   out  1         pixel passed thresholds
//  disp_filled_flag  out  1         pixel invalid, value copied from last valid in row
//  sol/eol           out  1 each    first/last pixel of output row (qualified by out_valid)
//  sof/eof           out  1 each    first/last pixel of output frame
//  out_valid         out  1         output pixel strobe
//  frame_valid_cnt   out  16        count of disp_valid_flag pixels in last complete frame
// BEHAVIOUR
//  - Reset: all outputs 0, all counters 0, last-valid register 0, hole run 0.
//  - Geometry: OW = FRAME_W/D px per row, OH = FRAME_H/D rows; beat counter b 0..D-1, col 0..OW-1,
//    row 0..OH-1. Counters advance only on pix_stream_valid; gaps of any length allowed anywhere.
//  - Accumulate: sum = popcount over D beats (width $clog2(D*D+1), 3 for D=2); cleared after beat D-1.
//  - Stage 1 (on beat D-1 registered): pass = (sum <= xor_thresh) && (conf_in >= conf_thresh);
//    disparity captured from this beat. Thresholds latched on first beat of each frame
//    (row=0,col=0,b=0); mid-frame changes take effect next frame.
//  - Stage 2 hole fill: pass -> out=disp, valid=1, last=disp, run=0.
//    !pass && have_last && run<MAX_HOLE -> out=last, filled=1, run++.
//    else -> out=0, both flags 0. have_last and run cleared at sol.
//  - Latency: out_valid exactly 2 cycles after the beat-D-1 input; one output per D input beats.
//  - Wrap: col OW-1 -> 0 with row++; row OH-1 & col OW-1 -> eof, all counters to 0.
//  - frame_valid_cnt updated with the running count on the eof cycle (includes eof pixel);
//    running count cleared on the same cycle. Saturates at 16'hFFFF.
//  - sol&eol never coincide (OW>1); sof coincides with sol, eof with eol.
//  - Reset mid-frame: pipeline flushed, no out_valid for partial pixels; next beat is pixel (0,0) b=0.
//  - Output cannot stall; downstream must accept every out_valid.
// STRUCTURE
//  - disp_pkg: geometry localparams (OW, OH, sum width) and a disp_pix_t struct
//    {disp, valid, filled, sol, eol, sof, eof}.
//  - One sub-module: disp_hole_fill (stage 2 + last-valid/run state), driven by disp_pix_t.
//  - Top holds beat/col/row counters, popcount accumulator, threshold latch, frame counter.
// TESTING
//  1) Full frame, all data=2'b00, conf=200, disp=7, thr=(1,100) -> 14400 px out, all disp=7, valid=1,
//     frame_valid_cnt=14400 after eof.
//  2) Cell bits {2'b11,2'b01} (sum 3), xor_thresh=2 -> invalid; prev px valid disp=9 -> out 9, filled=1.
//  3) Five consecutive failing px after valid disp=12, MAX_HOLE=4 -> four filled=12, fifth out=0 flags 0.
//  4) Row starts with failing px -> out 0 (no carry from previous row); sol on col 0, eol on col 119.
//  5) Random 0-5 cycle valid gaps -> identical output sequence to gap-free run, 2-cycle latency.
//  6) Reset asserted at row 50 col 60 b=1 -> no stray out_valid; next beats start at sof, count restarts.

Source files
------------

// File: rtl/disp_stream_filter_pkg.sv
// Shared geometry, pixel record and popcount helper for the disparity stream filter.
package disp_stream_filter_pkg;

  localparam int FRAME_W   = 240;
  localparam int FRAME_H   = 240;
  localparam int DECIMATE  = 2;
  localparam int DISP_BITS = 5;
  localparam int MAX_HOLE  = 4;

  localparam int OW     = FRAME_W / DECIMATE;
  localparam int OH     = FRAME_H / DECIMATE;
  localparam int SUM_W  = $clog2(DECIMATE * DECIMATE + 1);
  localparam int BEAT_W = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
  localparam int COL_W  = (OW > 1) ? $clog2(OW) : 1;
  localparam int ROW_W  = (OH > 1) ? $clog2(OH) : 1;
  localparam int RUN_W  = $clog2(MAX_HOLE + 1);

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(DECIMATE - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(OW - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(OH - 1);

  typedef struct packed {
    logic [7:0] disp;
    logic       valid;
    logic       filled;
    logic       sol;
    logic       eol;
    logic       sof;
    logic       eof;
  } disp_pix_t;

  function automatic logic [SUM_W-1:0] popcount(input logic [DECIMATE-1:0] bits);
    logic [SUM_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DECIMATE; i++) begin
      cnt = cnt + SUM_W'(bits[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/disp_stream_filter_if.sv
// XOR-stream input beats and filtered disparity pixel output of the filter.
interface disp_stream_filter_if;
  import disp_stream_filter_pkg::*;

  logic [DECIMATE-1:0] pix_stream_data;
  logic                pix_stream_valid;
  logic [7:0]          conf_in;
  logic [7:0]          disp_in;

  logic [7:0]          disp_out;
  logic                disp_valid_flag;
  logic                disp_filled_flag;
  logic                sol;
  logic                eol;
  logic                sof;
  logic                eof;
  logic                out_valid;

  // Upstream producer / downstream consumer side
  modport master (
    output pix_stream_data, pix_stream_valid, conf_in, disp_in,
    input  disp_out, disp_valid_flag, disp_filled_flag, sol, eol, sof, eof, out_valid
  );

  // Filter side
  modport slave (
    input  pix_stream_data, pix_stream_valid, conf_in, disp_in,
    output disp_out, disp_valid_flag, disp_filled_flag, sol, eol, sof, eof, out_valid
  );

endinterface

// File: rtl/disp_stream_filter_hole_fill.sv
// Stage 2: replaces short runs of failing pixels with the last passing value of the row.
module disp_hole_fill
  import disp_stream_filter_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  disp_pix_t pix_in,
  input  logic      pix_in_valid,
  output disp_pix_t pix_out,
  output logic      pix_out_valid
);

  logic [7:0]       last_q, last_d;
  logic             have_last_q, have_last_d;
  logic [RUN_W-1:0] run_q, run_d;
  disp_pix_t        out_q, out_d;
  logic             out_vld_q, out_vld_d;
  logic             have_eff;
  logic [RUN_W-1:0] run_eff;
  logic             unused_filled_in;

  assign unused_filled_in = pix_in.filled;

  // Decide pass / fill / blank for the incoming pixel; row state restarts at sol
  always_comb begin
    last_d      = last_q;
    have_last_d = have_last_q;
    run_d       = run_q;
    out_d       = '0;
    out_vld_d   = 1'b0;
    have_eff    = pix_in.sol ? 1'b0 : have_last_q;
    run_eff     = pix_in.sol ? '0 : run_q;
    if (pix_in_valid) begin
      out_vld_d   = 1'b1;
      out_d.sol   = pix_in.sol;
      out_d.eol   = pix_in.eol;
      out_d.sof   = pix_in.sof;
      out_d.eof   = pix_in.eof;
      have_last_d = have_eff;
      run_d       = run_eff;
      if (pix_in.valid) begin
        out_d.disp  = pix_in.disp;
        out_d.valid = 1'b1;
        last_d      = pix_in.disp;
        have_last_d = 1'b1;
        run_d       = '0;
      end else if (have_eff && (int'(run_eff) < MAX_HOLE)) begin
        out_d.disp   = last_q;
        out_d.filled = 1'b1;
        run_d        = run_eff + RUN_W'(1);
      end
    end
  end

  // Register the filled pixel and the per-row fill state
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= '0;
      have_last_q <= 1'b0;
      run_q       <= '0;
      out_q       <= '0;
      out_vld_q   <= 1'b0;
    end else begin
      last_q      <= last_d;
      have_last_q <= have_last_d;
      run_q       <= run_d;
      out_q       <= out_d;
      out_vld_q   <= out_vld_d;
    end
  end

  assign pix_out       = out_q;
  assign pix_out_valid = out_vld_q;

endmodule

// File: rtl/disp_stream_filter.sv
// Turns decimated XOR beats into thresholded, hole-filled raster disparity pixels.
module disp_stream_filter
  import disp_stream_filter_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  disp_stream_filter_if.slave  strm,
  input  logic [2:0]           xor_thresh,
  input  logic [7:0]           conf_thresh,
  output logic [15:0]          frame_valid_cnt
);

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [2:0]        xor_thr_q, xor_thr_d;
  logic [7:0]        conf_thr_q, conf_thr_d;
  disp_pix_t         pix1_q, pix1_d;
  logic              pix1_vld_q, pix1_vld_d;
  logic [15:0]       run_cnt_q, run_cnt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic              first_beat;
  logic [2:0]        xor_eff;
  logic [7:0]        conf_eff;
  logic [SUM_W-1:0]  acc;
  logic [15:0]       cnt_inc;
  disp_pix_t         fill_pix;
  logic              fill_vld;
  logic              unused_disp_bits;

  assign unused_disp_bits = ^strm.disp_in[7:DISP_BITS];

  // Beat/col/row tracking, popcount accumulation, threshold latch and stage-1 evaluation
  always_comb begin
    beat_d      = beat_q;
    col_d       = col_q;
    row_d       = row_q;
    sum_d       = sum_q;
    xor_thr_d   = xor_thr_q;
    conf_thr_d  = conf_thr_q;
    pix1_d      = '0;
    pix1_vld_d  = 1'b0;
    run_cnt_d   = run_cnt_q;
    frame_cnt_d = frame_cnt_q;

    first_beat = strm.pix_stream_valid && (beat_q == '0) && (col_q == '0) && (row_q == '0);
    xor_eff    = first_beat ? xor_thresh : xor_thr_q;
    conf_eff   = first_beat ? conf_thresh : conf_thr_q;
    acc        = sum_q + popcount(strm.pix_stream_data);

    if (first_beat) begin
      xor_thr_d  = xor_thresh;
      conf_thr_d = conf_thresh;
    end

    if (strm.pix_stream_valid) begin
      if (beat_q == BEAT_LAST) begin
        sum_d        = '0;
        beat_d       = '0;
        pix1_vld_d   = 1'b1;
        pix1_d.disp  = 8'(strm.disp_in[DISP_BITS-1:0]);
        pix1_d.valid = (int'(acc) <= int'(xor_eff)) && (strm.conf_in >= conf_eff);
        pix1_d.sol   = (col_q == '0);
        pix1_d.eol   = (col_q == COL_LAST);
        pix1_d.sof   = (col_q == '0) && (row_q == '0);
        pix1_d.eof   = (col_q == COL_LAST) && (row_q == ROW_LAST);
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end else begin
        sum_d  = acc;
        beat_d = beat_q + BEAT_W'(1);
      end
    end

    cnt_inc = (run_cnt_q == 16'hFFFF) ? run_cnt_q : run_cnt_q + 16'(pix1_q.valid);
    if (pix1_vld_q) begin
      if (pix1_q.eof) begin
        frame_cnt_d = cnt_inc;
        run_cnt_d   = '0;
      end else begin
        run_cnt_d = cnt_inc;
      end
    end
  end

  // State registers; reset flushes the pipeline and restarts at pixel (0,0)
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      sum_q       <= '0;
      xor_thr_q   <= '0;
      conf_thr_q  <= '0;
      pix1_q      <= '0;
      pix1_vld_q  <= 1'b0;
      run_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      beat_q      <= beat_d;
      col_q       <= col_d;
      row_q       <= row_d;
      sum_q       <= sum_d;
      xor_thr_q   <= xor_thr_d;
      conf_thr_q  <= conf_thr_d;
      pix1_q      <= pix1_d;
      pix1_vld_q  <= pix1_vld_d;
      run_cnt_q   <= run_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  disp_hole_fill u_hole_fill (
    .clk           (clk),
    .reset         (reset),
    .pix_in        (pix1_q),
    .pix_in_valid  (pix1_vld_q),
    .pix_out       (fill_pix),
    .pix_out_valid (fill_vld)
  );

  assign strm.disp_out         = fill_pix.disp;
  assign strm.disp_valid_flag  = fill_pix.valid;
  assign strm.disp_filled_flag = fill_pix.filled;
  assign strm.sol              = fill_pix.sol;
  assign strm.eol              = fill_pix.eol;
  assign strm.sof              = fill_pix.sof;
  assign strm.eof              = fill_pix.eof;
  assign strm.out_valid        = fill_vld;
  assign frame_valid_cnt       = frame_cnt_q;

endmodule

// File: tb/tb_disp_stream_filter.sv
// Directed + random bench for disp_stream_filter with a pixel scoreboard.
`timescale 1ns/1ps
module tb_disp_stream_filter;
  import disp_stream_filter_pkg::*;

  localparam int CELL_BITS = DECIMATE * DECIMATE;

  typedef struct {
    logic [7:0]  disp;
    logic        valid;
    logic        filled;
    logic        sol;
    logic        eol;
    logic        sof;
    logic        eof;
    logic [15:0] cnt;
    int          due;
    int          row;
    int          col;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  xor_thresh;
  logic [7:0]  conf_thresh;
  logic [15:0] frame_valid_cnt;

  int tests_run = 0;
  int fail_cnt  = 0;
  int cyc       = 0;

  exp_t sb[$];

  int         m_col, m_row, m_xor, m_conf, m_run, m_cnt;
  logic [7:0] m_last;
  bit         m_have;

  disp_stream_filter_if ifc();

  disp_stream_filter dut (
    .clk             (clk),
    .reset           (reset),
    .strm            (ifc.slave),
    .xor_thresh      (xor_thresh),
    .conf_thresh     (conf_thresh),
    .frame_valid_cnt (frame_valid_cnt)
  );

  // Free-running clock and cycle stamp used for latency checks
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Watchdog so a stuck run still terminates
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    m_col = 0; m_row = 0; m_run = 0; m_cnt = 0;
    m_last = 8'd0; m_have = 1'b0;
    m_xor = 0; m_conf = 0;
  endtask

  // Reference behaviour for one completed cell, queued with its due cycle
  task automatic modelPixel(input logic [CELL_BITS-1:0] bits, input logic [7:0] conf,
                            input logic [7:0] disp);
    exp_t e;
    bit   pass;
    pass     = ($countones(bits) <= m_xor) && (int'(conf) >= m_conf);
    e.disp   = 8'd0;
    e.valid  = 1'b0;
    e.filled = 1'b0;
    e.sol    = (m_col == 0);
    e.eol    = (m_col == OW - 1);
    e.sof    = e.sol && (m_row == 0);
    e.eof    = e.eol && (m_row == OH - 1);
    if (e.sol) begin
      m_have = 1'b0;
      m_run  = 0;
    end
    if (pass) begin
      e.disp  = disp & 8'((1 << DISP_BITS) - 1);
      e.valid = 1'b1;
      m_last  = e.disp;
      m_have  = 1'b1;
      m_run   = 0;
      if (m_cnt < 65535) m_cnt++;
    end else if (m_have && m_run < MAX_HOLE) begin
      e.disp   = m_last;
      e.filled = 1'b1;
      m_run++;
    end
    e.cnt = 16'(m_cnt);
    if (e.eof) m_cnt = 0;
    e.due = cyc + 2;
    e.row = m_row;
    e.col = m_col;
    sb.push_back(e);
    if (m_col == OW - 1) begin
      m_col = 0;
      m_row = (m_row == OH - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  // Drive one DxD cell; conf/disp are meaningful only on the last beat
  task automatic applyStimulus(input logic [CELL_BITS-1:0] bits, input logic [7:0] conf,
                               input logic [7:0] disp, input int max_gap);
    int gap;
    for (int b = 0; b < DECIMATE; b++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        ifc.pix_stream_valid = 1'b0;
        ifc.pix_stream_data  = DECIMATE'($urandom);
        ifc.conf_in          = 8'($urandom);
        ifc.disp_in          = 8'($urandom);
      end
      @(negedge clk);
      if (b == 0 && m_col == 0 && m_row == 0) begin
        m_xor  = int'(xor_thresh);
        m_conf = int'(conf_thresh);
      end
      ifc.pix_stream_valid = 1'b1;
      ifc.pix_stream_data  = bits[b*DECIMATE +: DECIMATE];
      if (b == DECIMATE - 1) begin
        ifc.conf_in = conf;
        ifc.disp_in = disp;
        modelPixel(bits, conf, disp);
      end else begin
        ifc.conf_in = 8'($urandom);
        ifc.disp_in = 8'($urandom);
      end
    end
  endtask

  task automatic driveRandom(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      applyStimulus(CELL_BITS'($urandom), 8'($urandom), 8'($urandom), max_gap);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ifc.pix_stream_valid = 1'b0;
      ifc.pix_stream_data  = DECIMATE'($urandom);
    end
  endtask

  // Compare each output pixel against the scoreboard head
  task automatic checkOutput();
    exp_t e;
    if (ifc.out_valid) begin
      tests_run++;
      assert (sb.size() > 0) else begin
        fail_cnt++;
        $error("[TB] FAIL unexpected_out: got out_valid=1 expected no pixel (cycle %0d)", cyc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests_run++;
        assert ({ifc.disp_out, ifc.disp_valid_flag, ifc.disp_filled_flag, ifc.sol, ifc.eol,
                 ifc.sof, ifc.eof} === {e.disp, e.valid, e.filled, e.sol, e.eol, e.sof, e.eof})
        else begin
          fail_cnt++;
          $error("[TB] FAIL pix_r%0d_c%0d: got disp=%0d v=%b f=%b sol=%b eol=%b sof=%b eof=%b expected disp=%0d v=%b f=%b sol=%b eol=%b sof=%b eof=%b",
                 e.row, e.col, ifc.disp_out, ifc.disp_valid_flag, ifc.disp_filled_flag,
                 ifc.sol, ifc.eol, ifc.sof, ifc.eof,
                 e.disp, e.valid, e.filled, e.sol, e.eol, e.sof, e.eof);
        end
        tests_run++;
        assert (cyc == e.due) else begin
          fail_cnt++;
          $error("[TB] FAIL latency_r%0d_c%0d: got cycle %0d expected %0d", e.row, e.col, cyc, e.due);
        end
        if (e.eof) begin
          tests_run++;
          assert (frame_valid_cnt === e.cnt) else begin
            fail_cnt++;
            $error("[TB] FAIL frame_valid_cnt_eof: got %0d expected %0d", frame_valid_cnt, e.cnt);
          end
        end
      end
    end else if (sb.size() > 0 && cyc >= sb[0].due) begin
      e = sb.pop_front();
      tests_run++;
      fail_cnt++;
      $error("[TB] FAIL missing_out_r%0d_c%0d: got no out_valid expected pixel by cycle %0d", e.row, e.col, e.due);
    end
  endtask

  always @(negedge clk) checkOutput();

  // Directed sequence: reset, clean frame, fill cases, gapped rows, mid-frame reset
  initial begin
    reset                = 1'b1;
    xor_thresh           = 3'd1;
    conf_thresh          = 8'd100;
    ifc.pix_stream_valid = 1'b0;
    ifc.pix_stream_data  = '0;
    ifc.conf_in          = 8'd0;
    ifc.disp_in          = 8'd0;
    modelReset();
    repeat (3) @(negedge clk);
    checkEq("reset_out_valid", 32'(ifc.out_valid), 32'd0);
    checkEq("reset_disp_out", 32'(ifc.disp_out), 32'd0);
    checkEq("reset_flags", 32'({ifc.disp_valid_flag, ifc.disp_filled_flag, ifc.sol, ifc.eol, ifc.sof, ifc.eof}), 32'd0);
    checkEq("reset_frame_cnt", 32'(frame_valid_cnt), 32'd0);
    reset = 1'b0;

    $display("[TB] frame 1: clean data, conf_thresh raised mid-frame");
    for (int r = 0; r < OH; r++) begin
      for (int c = 0; c < OW; c++) begin
        if (r == 60 && c == 0) conf_thresh = 8'd250;
        applyStimulus('0, 8'd200, 8'd7, 0);
      end
    end
    xor_thresh  = 3'd2;
    conf_thresh = 8'd100;
    idleCycles(4);
    checkEq("frame1_valid_cnt", 32'(frame_valid_cnt), 32'd14400);

    $display("[TB] frame 2: fill and threshold edge cases");
    applyStimulus(4'b0000, 8'd150, 8'd9, 0);
    applyStimulus(4'b1101, 8'd200, 8'd20, 0);
    applyStimulus(4'b0110, 8'd100, 8'hE5, 0);
    driveRandom(OW - 3, 0);
    applyStimulus(4'b0000, 8'd255, 8'd12, 0);
    for (int i = 0; i < 5; i++) applyStimulus(4'b0000, 8'd99, 8'd30, 0);
    driveRandom(OW - 7, 0);
    applyStimulus(4'b0000, 8'd255, 8'd17, 0);
    applyStimulus(4'b1111, 8'd255, 8'd21, 0);
    driveRandom(OW - 1, 0);

    $display("[TB] frame 2: rows with random valid gaps");
    driveRandom(6 * OW, 5);
    driveRandom(41 * OW + 60, 0);

    $display("[TB] reset at row 50 col 60 beat 1");
    @(negedge clk);
    ifc.pix_stream_valid = 1'b1;
    ifc.pix_stream_data  = DECIMATE'($urandom);
    @(negedge clk);
    reset               = 1'b1;
    ifc.pix_stream_data = DECIMATE'($urandom);
    @(negedge clk);
    ifc.pix_stream_valid = 1'b0;
    sb.delete();
    modelReset();
    checkEq("midreset_out_valid", 32'(ifc.out_valid), 32'd0);
    checkEq("midreset_frame_cnt", 32'(frame_valid_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idleCycles(4);
    driveRandom(OW, 0);
    idleCycles(5);
    checkEq("sb_drained", 32'(sb.size()), 32'd0);
    checkEq("post_reset_frame_cnt", 32'(frame_valid_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
